lfsr_share_ctrl: RTL and testbench

Two-requester round-robin scheduler that time-shares one lfsr4 core (4-bit LFSR with 3-bit tap-mode select, `mod`).
Each requester submits a job of (mode, step count) over a valid/ready handshake. The controller seeds the core with that mode, lets it run exactly that many steps, captures the 4-bit value and returns it to the requester over a response handshake.
Sits between the top-level pin mux and the lfsr4 instance; it is the only driver of the core's reset and mod inputs.

---
 rtl/lfsr_share_ctrl.sv | 112 +++++++++++
 tb/tb_lfsr_share_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_share_ctrl.sv
// rtl/lfsr_share_ctrl.sv - two-requester round-robin scheduler time-sharing one lfsr4 core
// Optional response timeout enabled by defining LFSR_RSP_TIMEOUT_EN.
module lfsr_share_ctrl #(
  parameter int STEP_W    = 8,
  parameter int TO_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [5:0]            req_mod,
  input  logic [2*STEP_W-1:0]   req_steps,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [3:0]            rsp_data,
  input  logic [1:0]            rsp_ready,
  output logic                  lfsr_reset,
  output logic [2:0]            lfsr_mod,
  input  logic [3:0]            lfsr_val,
  output logic                  busy,
  output logic                  owner,
  output logic                  rsp_drop
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEED = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state;
  logic [STEP_W-1:0] cnt;
  logic              rr;
  logic [1:0]        grant;
  logic              rsp_hs;
  logic              rsp_timeout;

  // rr names the requester that wins when both are valid.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) grant[rr] = 1'b1;
    else                    grant = req_valid;
  end

  assign req_ready  = (state == S_IDLE && !reset) ? grant : 2'b00;
  assign rsp_valid  = (state == S_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_hs     = (state == S_RESP) && rsp_ready[owner];
  assign busy       = (state != S_IDLE);
  assign lfsr_reset = (state != S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rr       <= 1'b0;
      owner    <= 1'b0;
      lfsr_mod <= 3'b000;
      rsp_data <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid != 2'b00) begin
            lfsr_mod <= grant[1] ? req_mod[5:3] : req_mod[2:0];
            cnt      <= grant[1] ? req_steps[2*STEP_W-1:STEP_W] : req_steps[STEP_W-1:0];
            owner    <= grant[1];
            state    <= S_SEED;
          end
        end
        S_SEED: state <= S_RUN;
        S_RUN: begin
          // The core advances on this same edge, so the value seen at cnt==0 is after exactly `steps` advances.
          if (cnt != '0) begin
            cnt <= cnt - STEP_W'(1);
          end else begin
            rsp_data <= lfsr_val;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_hs || rsp_timeout) begin
            state <= S_IDLE;
            rr    <= ~owner;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LFSR_RSP_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt;

  // A handshake in the last allowed cycle wins over the timeout.
  assign rsp_timeout = (state == S_RESP) && !rsp_hs && (to_cnt == TO_W'(TO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt   <= '0;
      rsp_drop <= 1'b0;
    end else if (state != S_RESP) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
      if (rsp_timeout) rsp_drop <= 1'b1;
    end
  end
`else
  assign rsp_timeout = 1'b0;
  // TO_CYCLES has no effect without the timeout; the comparison is constant false.
  assign rsp_drop    = (TO_CYCLES < 0);
`endif

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// tb/tb_lfsr_share_ctrl.sv - directed self-checking bench for lfsr_share_ctrl with a behavioural lfsr4 core
module tb_lfsr_share_ctrl;
  localparam int STEP_W    = 8;
  localparam int TO_CYCLES = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid;
  logic [5:0]          req_mod;
  logic [2*STEP_W-1:0] req_steps;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [3:0]          rsp_data;
  logic [1:0]          rsp_ready;
  logic                lfsr_reset;
  logic [2:0]          lfsr_mod;
  logic [3:0]          lfsr_val;
  logic                busy;
  logic                owner;
  logic                rsp_drop;

  int checks = 0;
  int errors = 0;

  lfsr_share_ctrl #(.STEP_W(STEP_W), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_mod(req_mod), .req_steps(req_steps), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .lfsr_reset(lfsr_reset), .lfsr_mod(lfsr_mod), .lfsr_val(lfsr_val),
    .busy(busy), .owner(owner), .rsp_drop(rsp_drop)
  );

  always #5 clk = ~clk;

  // lfsr4 core: seed 0001, shift left, feedback = b3 ^ (mod0&b2) ^ (mod1&b1) ^ (mod2&b0).
  logic [3:0] core;
  always_ff @(posedge clk) begin
    if (lfsr_reset) core <= 4'b0001;
    else core <= {core[2:0], core[3] ^ (lfsr_mod[0] & core[2]) ^ (lfsr_mod[1] & core[1]) ^ (lfsr_mod[2] & core[0])};
  end
  assign lfsr_val = core;

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; req_mod = 6'b010_001; req_steps = {8'd3, 8'd3}; rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready cyc%0d got %b want 00", i, req_ready); end
      checks++; if (rsp_valid !== 2'b00 || lfsr_reset !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_outputs cyc%0d got rsp_valid=%b lfsr_reset=%b busy=%b want 00/1/0", i, rsp_valid, lfsr_reset, busy); end
    end
    checks++; if (rsp_data !== 4'b0000 || lfsr_mod !== 3'b000 || owner !== 1'b0 || rsp_drop !== 1'b0) begin
      errors++; $display("FAIL reset_regs got data=%b mod=%b owner=%b drop=%b want 0000/000/0/0", rsp_data, lfsr_mod, owner, rsp_drop); end
    req_valid = 2'b00; reset = 1'b0;
    tick();
  endtask

  task automatic test_single_job();
    int cyc, low;
    req_mod = 6'b000_001; req_steps = {8'd0, 8'd5}; rsp_ready = 2'b01; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_accept got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00; #1;
    checks++; if (req_ready !== 2'b00 || lfsr_reset !== 1'b1 || busy !== 1'b1 || lfsr_mod !== 3'b001 || owner !== 1'b0) begin
      errors++; $display("FAIL single_seed got ready=%b lres=%b busy=%b mod=%b owner=%b want 00/1/1/001/0", req_ready, lfsr_reset, busy, lfsr_mod, owner); end
    cyc = 1; low = 0;
    while (rsp_valid[0] !== 1'b1 && cyc < 40) begin
      tick(); cyc++;
      if (lfsr_reset === 1'b0) low++;
    end
    checks++; if (cyc != 8) begin errors++; $display("FAIL single_latency got %0d want 8", cyc); end
    checks++; if (low != 6) begin errors++; $display("FAIL single_run_cycles got %0d want 6", low); end
    checks++; if (rsp_data !== 4'b0110 || rsp_valid !== 2'b01) begin errors++; $display("FAIL single_data got %b/%b want 0110/01", rsp_data, rsp_valid); end
    tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || lfsr_reset !== 1'b1) begin
      errors++; $display("FAIL single_idle got busy=%b rsp_valid=%b lres=%b want 0/00/1", busy, rsp_valid, lfsr_reset); end
  endtask

  task automatic test_steps_zero();
    int cyc;
    req_mod = 6'b010_000; req_steps = {8'd0, 8'd0}; rsp_ready = 2'b10; req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_accept got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    cyc = 1;
    while (rsp_valid[1] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    checks++; if (cyc != 3) begin errors++; $display("FAIL zero_latency got %0d want 3", cyc); end
    checks++; if (rsp_data !== 4'b0001 || rsp_valid !== 2'b10 || owner !== 1'b1) begin
      errors++; $display("FAIL zero_data got %b/%b/%b want 0001/10/1", rsp_data, rsp_valid, owner); end
    tick();
  endtask

  task automatic test_contention();
    int ng, nr;
    bit both;
    ng = 0; nr = 0; both = 1'b0;
    req_mod = 6'b010_001; req_steps = {8'd2, 8'd2}; rsp_ready = 2'b11; req_valid = 2'b11;
    #1;
    for (int i = 0; i < 100 && nr < 4; i++) begin
      if (req_ready !== 2'b00) begin
        checks++; if (req_ready !== ((ng % 2 != 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contention_grant%0d got %b want %b", ng, req_ready, (ng % 2 != 0) ? 2'b10 : 2'b01); end
        ng++;
      end
      if (rsp_valid === 2'b11) both = 1'b1;
      if (rsp_valid !== 2'b00) begin
        checks++; if (rsp_data !== ((nr % 2 != 0) ? 4'b0101 : 4'b0100) || owner !== (nr % 2 != 0)) begin
          errors++; $display("FAIL contention_rsp%0d got data=%b owner=%b want %b/%0d", nr, rsp_data, owner, (nr % 2 != 0) ? 4'b0101 : 4'b0100, nr % 2); end
        nr++;
        if (nr == 4) req_valid = 2'b00;
      end
      tick();
    end
    checks++; if (ng != 4 || nr != 4) begin errors++; $display("FAIL contention_count got grants=%0d rsps=%0d want 4/4", ng, nr); end
    checks++; if (both) begin errors++; $display("FAIL contention_onehot got both rsp_valid bits set want never"); end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit bad;
    req_mod = 6'b010_001; req_steps = {8'd2, 8'd2}; rsp_ready = 2'b00; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    cyc = 0;
    while (rsp_valid[0] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    checks++; if (cyc >= 40) begin errors++; $display("FAIL bp_wait got timeout want rsp_valid[0]"); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_data !== 4'b0100 || req_ready !== 2'b00 || rsp_valid !== 2'b01) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_hold got data/ready/valid changed want 0100/00/01 for 10 cycles"); end
    rsp_ready = 2'b01; #1;
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_release got ready=%b valid=%b want 00/01", req_ready, rsp_valid); end
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00; rsp_ready = 2'b10;
    cyc = 0;
    while (rsp_valid[1] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    checks++; if (rsp_data !== 4'b0101 || rsp_drop !== 1'b0) begin errors++; $display("FAIL bp_second got data=%b drop=%b want 0101/0", rsp_data, rsp_drop); end
    tick();
  endtask

  task automatic test_max_steps();
    int cyc;
    req_mod = 6'b000_001; req_steps = {8'd0, 8'd255}; rsp_ready = 2'b01; req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    cyc = 1;
    while (rsp_valid[0] !== 1'b1 && cyc < 400) begin tick(); cyc++; end
    checks++; if (cyc != 258) begin errors++; $display("FAIL max_latency got %0d want 258", cyc); end
    checks++; if (rsp_data !== 4'b0001) begin errors++; $display("FAIL max_data got %b want 0001", rsp_data); end
    tick();
  endtask

`ifdef LFSR_RSP_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, n;
    req_mod = 6'b010_001; req_steps = {8'd0, 8'd0}; rsp_ready = 2'b00; req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b10;
    cyc = 0;
    while (rsp_valid[0] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    n = 0;
    while (rsp_valid[0] === 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != TO_CYCLES) begin errors++; $display("FAIL to_duration got %0d want %0d", n, TO_CYCLES); end
    checks++; if (rsp_drop !== 1'b1 || busy !== 1'b0 || req_ready !== 2'b10) begin
      errors++; $display("FAIL to_drop got drop=%b busy=%b ready=%b want 1/0/10", rsp_drop, busy, req_ready); end
    tick();
    req_valid = 2'b00; rsp_ready = 2'b10;
    cyc = 0;
    while (rsp_valid[1] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    tick();
    checks++; if (rsp_drop !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_sticky got drop=%b busy=%b want 1/0", rsp_drop, busy); end
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_mod = '0; req_steps = '0; rsp_ready = 2'b00;
    test_reset();
    test_single_job();
    test_steps_zero();
    test_contention();
    test_backpressure();
    test_max_steps();
`ifdef LFSR_RSP_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
